// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM states,
// opcode values, ALU-decoder operation codes and the bundled control word.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_BNEEX   = 4'd9,
        S_IMMEX   = 4'd10,
        S_IMMWB   = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    // Opcode field values recognised by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALUOp codes understood by the ALU decoder; 3'b101 is reserved
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_SLT   = 3'b011;
    localparam logic [2:0] ALUOP_BNE   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b110;
    localparam logic [2:0] ALUOP_XOR   = 3'b111;

    // ALU B-operand mux selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // Next-PC mux selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       i_or_d;
        logic       alu_src_a;
        logic       zero_ext;
        logic       illegal_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
    } ctrl_t;

    // True for every opcode the controller knows how to sequence
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
            OP_ADDI, OP_SLTI, OP_ORI, OP_XORI,
            OP_LW, OP_SW: legal = 1'b1;
            default:      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-control-word decoder for the multicycle controller.
// Outputs are a function of the current state; the opcode only refines the
// DECODE illegal flag and the IMMEX ALU operation, and MemReady only gates
// the FETCH write strobes.
module mips_ctrl_outdec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Decode the control word for the current state; anything unlisted stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                // Latch the instruction and bump PC only once memory delivers
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_BRANCH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = ~op_is_legal(op);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.i_or_d = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                // Held for the full duration of a stalled store
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_BNEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_BNE;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch_ne = 1'b1;
            end
            S_IMMEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                case (op)
                    OP_SLTI: ctrl.alu_op = ALUOP_SLT;
                    OP_ORI:  ctrl.alu_op = ALUOP_OR;
                    OP_XORI: ctrl.alu_op = ALUOP_XOR;
                    default: ctrl.alu_op = ALUOP_ADD;
                endcase
                // Logical immediates are zero-extended, arithmetic ones sign-extended
                ctrl.zero_ext = (op == OP_ORI) || (op == OP_XORI);
            end
            S_IMMWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: state register, next-state logic and the
// output decoder. Architectural write strobes are suppressed while reset is
// held so nothing is committed during reset.
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       BranchNE,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       ZeroExt,
    output logic       IllegalOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;

    // State register; reset abandons any instruction and returns to FETCH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state sequencing; Op only steers DECODE and MEMADR
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                state_next = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:                       state_next = S_MEMADR;
                    OP_RTYPE:                           state_next = S_EXECUTE;
                    OP_BEQ:                             state_next = S_BEQEX;
                    OP_BNE:                             state_next = S_BNEEX;
                    OP_ADDI, OP_SLTI, OP_ORI, OP_XORI:  state_next = S_IMMEX;
                    OP_J:                               state_next = S_JUMP;
                    default:                            state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_next = S_FETCH;
            S_MEMWR:   state_next = MemReady ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_next = S_ALUWB;
            S_ALUWB:   state_next = S_FETCH;
            S_BEQEX:   state_next = S_FETCH;
            S_BNEEX:   state_next = S_FETCH;
            S_IMMEX:   state_next = S_IMMWB;
            S_IMMWB:   state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
            default:   state_next = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state     (state_reg),
        .op        (Op),
        .mem_ready (MemReady),
        .ctrl      (ctrl)
    );

    // Write strobes are qualified with reset so MemReady cannot leak through
    // the FETCH decode while the block is held in reset
    assign IRWrite   = ctrl.ir_write   & reset_n;
    assign PCWrite   = ctrl.pc_write   & reset_n;
    assign MemWrite  = ctrl.mem_write  & reset_n;
    assign RegWrite  = ctrl.reg_write  & reset_n;
    assign IllegalOp = ctrl.illegal_op & reset_n;

    assign Branch    = ctrl.branch;
    assign BranchNE  = ctrl.branch_ne;
    assign RegDst    = ctrl.reg_dst;
    assign MemtoReg  = ctrl.mem_to_reg;
    assign IorD      = ctrl.i_or_d;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ZeroExt   = ctrl.zero_ext;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign PCSrc     = ctrl.pc_src;
    assign ALUOp     = ctrl.alu_op;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle controller: each instruction is a list of
// per-cycle (expected state, Op, MemReady) entries; every cycle the full
// control word is compared against the value expected for that state.
module tb_mips_multicycle_control;

    localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMRD = 3,
                   T_MEMWB = 4, T_MEMWR = 5, T_EXECUTE = 6, T_ALUWB = 7,
                   T_BEQEX = 8, T_BNEEX = 9, T_IMMEX = 10, T_IMMWB = 11,
                   T_JUMP = 12;

    localparam logic [5:0] C_RTYPE = 6'b000000, C_J = 6'b000010,
                           C_BEQ = 6'b000100, C_BNE = 6'b000101,
                           C_ADDI = 6'b001000, C_SLTI = 6'b001010,
                           C_ORI = 6'b001101, C_XORI = 6'b001110,
                           C_LW = 6'b100011, C_SW = 6'b101011,
                           C_BAD = 6'b111111;

    logic       clk;
    logic       reset_n;
    logic [5:0] Op;
    logic       MemReady;
    logic       IRWrite, PCWrite, Branch, BranchNE, MemWrite, RegWrite;
    logic       RegDst, MemtoReg, IorD, ALUSrcA, ZeroExt, IllegalOp;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUOp;

    int n_checks = 0;
    int n_fail   = 0;

    int         q_st[$];
    logic [5:0] q_op[$];
    logic       q_mr[$];

    mips_multicycle_control dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Op        (Op),
        .MemReady  (MemReady),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .BranchNE  (BranchNE),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .IorD      (IorD),
        .ALUSrcA   (ALUSrcA),
        .ZeroExt   (ZeroExt),
        .IllegalOp (IllegalOp),
        .ALUSrcB   (ALUSrcB),
        .PCSrc     (PCSrc),
        .ALUOp     (ALUOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string st_name(int st);
        case (st)
            T_FETCH:   return "FETCH";
            T_DECODE:  return "DECODE";
            T_MEMADR:  return "MEMADR";
            T_MEMRD:   return "MEMRD";
            T_MEMWB:   return "MEMWB";
            T_MEMWR:   return "MEMWR";
            T_EXECUTE: return "EXECUTE";
            T_ALUWB:   return "ALUWB";
            T_BEQEX:   return "BEQEX";
            T_BNEEX:   return "BNEEX";
            T_IMMEX:   return "IMMEX";
            T_IMMWB:   return "IMMWB";
            T_JUMP:    return "JUMP";
            default:   return "UNKNOWN";
        endcase
    endfunction

    // Control word {IRWrite,PCWrite,Branch,BranchNE,MemWrite,RegWrite,RegDst,
    // MemtoReg,IorD,ALUSrcA,ZeroExt,IllegalOp,ALUSrcB,PCSrc,ALUOp} per state
    function automatic logic [18:0] exp_word(int st, logic [5:0] op, logic mr, logic rn);
        logic irw, pcw, br, bne, mw, rw, rd, m2r, iord, asa, zx, ill;
        logic [1:0] asb, pcs;
        logic [2:0] aop;
        {irw, pcw, br, bne, mw, rw, rd, m2r, iord, asa, zx, ill} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 3'b000;
        case (st)
            T_FETCH:   begin asb = 2'b01; irw = mr & rn; pcw = mr & rn; end
            T_DECODE:  begin
                asb = 2'b11;
                ill = !(op inside {C_RTYPE, C_J, C_BEQ, C_BNE, C_ADDI, C_SLTI,
                                   C_ORI, C_XORI, C_LW, C_SW});
            end
            T_MEMADR:  begin asa = 1'b1; asb = 2'b10; end
            T_MEMRD:   begin iord = 1'b1; end
            T_MEMWB:   begin m2r = 1'b1; rw = 1'b1; end
            T_MEMWR:   begin iord = 1'b1; mw = 1'b1; end
            T_EXECUTE: begin asa = 1'b1; aop = 3'b010; end
            T_ALUWB:   begin rd = 1'b1; rw = 1'b1; end
            T_BEQEX:   begin asa = 1'b1; aop = 3'b001; pcs = 2'b01; br = 1'b1; end
            T_BNEEX:   begin asa = 1'b1; aop = 3'b100; pcs = 2'b01; bne = 1'b1; end
            T_IMMEX:   begin
                asa = 1'b1; asb = 2'b10;
                if (op == C_SLTI)      aop = 3'b011;
                else if (op == C_ORI)  begin aop = 3'b110; zx = 1'b1; end
                else if (op == C_XORI) begin aop = 3'b111; zx = 1'b1; end
            end
            T_IMMWB:   begin rw = 1'b1; end
            T_JUMP:    begin pcs = 2'b10; pcw = 1'b1; end
            default:   ;
        endcase
        return {irw, pcw, br, bne, mw, rw, rd, m2r, iord, asa, zx, ill, asb, pcs, aop};
    endfunction

    function automatic logic [18:0] got_word();
        return {IRWrite, PCWrite, Branch, BranchNE, MemWrite, RegWrite, RegDst,
                MemtoReg, IorD, ALUSrcA, ZeroExt, IllegalOp, ALUSrcB, PCSrc, ALUOp};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int st, input logic [5:0] op, input logic mr);
        q_st.push_back(st);
        q_op.push_back(op);
        q_mr.push_back(mr);
    endtask

    // Play the queued cycles; sample outputs 1 time unit after the falling edge
    task automatic run_seq(input string name);
        int nerr;
        nerr = n_fail;
        for (int i = 0; i < q_st.size(); i++) begin
            @(negedge clk);
            Op       = q_op[i];
            MemReady = q_mr[i];
            #1;
            check_eq($sformatf("%s c%0d %s", name, i, st_name(q_st[i])),
                     {13'd0, got_word()}, {13'd0, exp_word(q_st[i], q_op[i], q_mr[i], 1'b1)});
        end
        $display("%s: %0d cycles, %0d errors", name, q_st.size(), n_fail - nerr);
        q_st.delete();
        q_op.delete();
        q_mr.delete();
    endtask

    task automatic std_instr(input string name, input logic [5:0] op, input int st2, input int st3);
        push(T_FETCH, op, 1'b1);
        push(T_DECODE, op, 1'b1);
        push(st2, op, 1'b1);
        if (st3 >= 0) push(st3, op, 1'b1);
        run_seq(name);
    endtask

    initial begin
        reset_n  = 1'b0;
        Op       = C_RTYPE;
        MemReady = 1'b1;

        // Reset state: FETCH decode with write strobes suppressed
        @(negedge clk); #1;
        check_eq("reset word", {13'd0, got_word()}, {13'd0, exp_word(T_FETCH, Op, 1'b1, 1'b0)});
        @(negedge clk);
        MemReady = 1'b0;
        reset_n  = 1'b1;
        #1;
        check_eq("post-reset FETCH", {13'd0, got_word()}, {13'd0, exp_word(T_FETCH, Op, 1'b0, 1'b1)});

        // R-type, 4 cycles
        std_instr("RTYPE", C_RTYPE, T_EXECUTE, T_ALUWB);

        // LW with two stall cycles in MEMRD; Op changes after MEMADR are ignored
        push(T_FETCH, C_LW, 1'b1);
        push(T_DECODE, C_LW, 1'b1);
        push(T_MEMADR, C_LW, 1'b1);
        push(T_MEMRD, C_SW, 1'b0);
        push(T_MEMRD, C_BAD, 1'b0);
        push(T_MEMRD, C_J, 1'b1);
        push(T_MEMWB, C_BEQ, 1'b1);
        run_seq("LW stall");

        // Immediates
        std_instr("ORI",  C_ORI,  T_IMMEX, T_IMMWB);
        std_instr("SLTI", C_SLTI, T_IMMEX, T_IMMWB);
        std_instr("ADDI", C_ADDI, T_IMMEX, T_IMMWB);
        std_instr("XORI", C_XORI, T_IMMEX, T_IMMWB);

        // SW with a fetch stall and a store stall
        push(T_FETCH, C_SW, 1'b0);
        push(T_FETCH, C_SW, 1'b1);
        push(T_DECODE, C_SW, 1'b1);
        push(T_MEMADR, C_SW, 1'b1);
        push(T_MEMWR, C_LW, 1'b0);
        push(T_MEMWR, C_LW, 1'b1);
        run_seq("SW stall");

        // Branches, jump, illegal opcode
        std_instr("BEQ", C_BEQ, T_BEQEX, -1);
        std_instr("BNE", C_BNE, T_BNEEX, -1);
        std_instr("J",   C_J,   T_JUMP,  -1);
        push(T_FETCH, C_BAD, 1'b1);
        push(T_DECODE, C_BAD, 1'b1);
        run_seq("ILLEGAL");

        // Reset during a MEMWR hold
        push(T_FETCH, C_SW, 1'b1);
        push(T_DECODE, C_SW, 1'b1);
        push(T_MEMADR, C_SW, 1'b1);
        push(T_MEMWR, C_SW, 1'b0);
        push(T_MEMWR, C_SW, 1'b0);
        run_seq("SW hold");
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("reset MemWrite", {31'd0, MemWrite}, 32'd0);
        check_eq("reset mid word", {13'd0, got_word()}, {13'd0, exp_word(T_FETCH, Op, 1'b0, 1'b0)});
        @(negedge clk);
        MemReady = 1'b1;
        #1;
        check_eq("reset held word", {13'd0, got_word()}, {13'd0, exp_word(T_FETCH, Op, 1'b1, 1'b0)});
        @(negedge clk);
        MemReady = 1'b0;
        reset_n  = 1'b1;
        #1;
        check_eq("release FETCH", {13'd0, got_word()}, {13'd0, exp_word(T_FETCH, Op, 1'b0, 1'b1)});

        // Normal operation resumes after reset
        std_instr("RTYPE after reset", C_RTYPE, T_EXECUTE, T_ALUWB);
        push(T_FETCH, C_RTYPE, 1'b0);
        run_seq("final FETCH");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
